// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: access size, bus FSM state and the MEM/WB register.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_e;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rw;
        logic [31:0] data;
        logic [29:0] pcp1;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/half lane and sign- or zero-extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = rdata_i;
        case (mem_size_e'(size_i))
            MemByte: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            MemHalf: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-bus access, load alignment, MEM/WB register and MEM branch correction.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_flush,
    input  logic [29:0] in_pcp1,
    input  logic [4:0]  in_rw,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_wdata,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic [2:0]  in_branch_type,
    input  logic        in_branch_at_mem,
    input  logic        in_pred_avail,
    input  logic [29:0] in_bpc,
    input  logic [29:0] in_nojpc,
    input  logic        in_ex_branch_avail,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        back_regwrite,
    output logic [4:0]  back_rw,
    output logic [31:0] back_data,
    output logic        correct_at_mem,
    output logic [29:0] correct_pc_at_mem,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rw,
    output logic [31:0] wb_data,
    output logic [29:0] wb_pcp1,
    output logic        addr_err,
    output logic        bus_err
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_check
        $error("CNT_W too narrow to hold TIMEOUT");
    end

    mem_state_e  state_q, state_d;
    mem_size_e   size;
    mem_wb_t     wb_q, wb_d;
    logic        aligned, is_mem, access, misaligned, timeout, bubble;
    logic        kill_q, kill_d, addr_err_q, bus_err_q;
    logic [31:0] load_data;

    assign size       = mem_size_e'(in_size);
    assign is_mem     = in_memread | in_memwrite;
    assign access     = is_mem & aligned;
    assign misaligned = is_mem & ~aligned;

    always_comb begin
        aligned  = 1'b1;
        dm_be    = 4'b1111;
        dm_wdata = in_wdata;
        case (size)
            MemByte: begin
                dm_be    = 4'b0001 << in_alu[1:0];
                dm_wdata = {4{in_wdata[7:0]}};
            end
            MemHalf: begin
                aligned  = ~in_alu[0];
                dm_be    = in_alu[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{in_wdata[15:0]}};
            end
            default: aligned = (in_alu[1:0] == 2'b00);
        endcase
    end

    assign dm_addr = {in_alu[31:2], 2'b00};
    assign dm_we   = in_memwrite;

    // A watchdog expiry drops the request in the same cycle so the held instruction retires as a bubble.
    always_comb begin
        state_d = state_q;
        dm_req  = 1'b0;
        unique case (state_q)
            StIdle: begin
                dm_req = access;
                if (access && !dm_ack) state_d = StWait;
            end
            StWait: begin
                if (timeout) begin
                    state_d = StIdle;
                end else begin
                    dm_req = 1'b1;
                    if (dm_ack) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_stall = dm_req & ~dm_ack;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign cnt_d   = (state_q == StWait && !timeout && !dm_ack) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    mem_stage_load_align u_load_align (
        .rdata_i   (dm_rdata),
        .lane_i    (in_alu[1:0]),
        .size_i    (in_size),
        .unsigned_i(in_unsigned),
        .data_o    (load_data)
    );

    // A flush seen while stalled must still discard the result when the ack finally arrives.
    assign kill_d = mem_stall & (kill_q | mem_flush);
    assign bubble = mem_flush | kill_q | misaligned | mem_stall | timeout;

    always_comb begin
        wb_d.regwrite = in_regwrite;
        wb_d.rw       = in_rw;
        wb_d.data     = in_memtoreg ? load_data : in_alu;
        wb_d.pcp1     = in_pcp1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            kill_q     <= 1'b0;
            wb_q       <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            addr_err_q <= misaligned;
            bus_err_q  <= timeout;
            if (bubble) wb_q.regwrite <= 1'b0;
            else        wb_q          <= wb_d;
        end
    end

    assign wb_regwrite = wb_q.regwrite;
    assign wb_rw       = wb_q.rw;
    assign wb_data     = wb_q.data;
    assign wb_pcp1     = wb_q.pcp1;
    assign addr_err    = addr_err_q;
    assign bus_err     = bus_err_q;

    assign back_regwrite = in_regwrite & ~in_memtoreg;
    assign back_rw       = in_rw;
    assign back_data     = in_alu;

    assign correct_at_mem = ~mem_flush && (in_branch_type != 3'd0) && in_branch_at_mem &&
                            (in_pred_avail != in_ex_branch_avail);
    assign correct_pc_at_mem = in_ex_branch_avail ? in_bpc : in_nojpc;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of EX; consumes the EX/MEM register contents (MEM_DATA, MEM_CTRL, WB_CTRL, branchCommit, EXBranchAvail).
- Performs the data-memory access over a req/ack bus, aligns and extends load data, and resolves MEM-committed branch mispredictions.
- Drives MEM_BACK bypass and the MEM/WB pipeline register; requests a pipeline stall while a bus access is outstanding.

Parameters:
- TIMEOUT, 16, watchdog limit in cycles (used only with MEM_TIMEOUT_EN).
- CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk in 1: clock.
- rst in 1: reset.
- mem_flush in 1: controller flush for this stage.
- in_pcp1 in 30: PC+4 [31:2]. in_rw in 5: destination reg. in_alu in 32: EX result / address. in_wdata in 32: store data (forwarded rd2).
- in_memread in 1, in_memwrite in 1, in_size in 2 (0 byte, 1 half, 2 word), in_unsigned in 1: MEM_CTRL.
- in_regwrite in 1, in_memtoreg in 1: WB_CTRL.
- in_branch_type in 3, in_branch_at_mem in 1, in_pred_avail in 1, in_bpc in 30, in_nojpc in 30, in_ex_branch_avail in 1: branch commit.
- dm_req out 1, dm_we out 1, dm_addr out 32, dm_be out 4, dm_wdata out 32, dm_ack in 1, dm_rdata in 32: data bus.
- mem_stall out 1: stall request to controller.
- back_regwrite out 1, back_rw out 5, back_data out 32: MEM_BACK bypass.
- correct_at_mem out 1, correct_pc_at_mem out 30: branch correction.
- wb_regwrite out 1, wb_rw out 5, wb_data out 32, wb_pcp1 out 30: MEM/WB register.
- addr_err out 1: misaligned-access pulse. bus_err out 1: watchdog pulse.

Behaviour:
- Reset is synchronous and active-high: on posedge clk with rst high, state=IDLE, counter=0, and all registered outputs are 0 (wb_*, addr_err, bus_err).
- access = (in_memread|in_memwrite) && aligned.
- aligned: byte always; half requires in_alu[0]=0; word requires in_alu[1:0]=0.
- Misaligned access: no dm_req is issued; addr_err=1 for one cycle; the MEM/WB slot becomes a bubble (wb_regwrite=0).
- Bus outputs:
  - dm_addr={in_alu[31:2],2'b00}; dm_we=in_memwrite.
  - dm_be: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - dm_wdata replicates the byte/half into all lanes.
- FSM, IDLE/WAIT:
  - IDLE: dm_req=access. If dm_ack arrives the same cycle, the access completes in zero extra cycles. Otherwise go to WAIT.
  - WAIT: dm_req=1; EX/MEM inputs are held stable by the stall. On dm_ack, go to IDLE.
- mem_stall = dm_req && !dm_ack (combinational).
- A pending access is never retracted. mem_flush during WAIT does not abort it; the stall holds until ack, then the result is discarded.
- Load extraction:
  - lane = addr[1:0].
  - Byte is sign- or zero-extended per in_unsigned; half uses addr[1].
  - wb_data = in_memtoreg ? loaddata : in_alu.
- MEM/WB register update on posedge (priority order):
  1. rst: clear.
  2. mem_flush or misaligned or mem_stall: wb_regwrite=0 (bubble); other wb_* fields are don't-care.
  3. Otherwise: latch rw, data, pcp1, and regwrite.
- Bypass:
  - back_regwrite = in_regwrite && !in_memtoreg; back_rw=in_rw; back_data=in_alu.
  - Load-use hazards are handled by stall detection, not here.
- Branch correction (combinational):
  - correct_at_mem = !mem_flush && in_branch_type!=0 && in_branch_at_mem && (in_pred_avail != in_ex_branch_avail).
  - correct_pc_at_mem = in_ex_branch_avail ? in_bpc : in_nojpc.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - The counter increments each WAIT cycle.
  - When it reaches TIMEOUT without ack: force IDLE, drop dm_req, pulse bus_err for one cycle, insert a bubble, clear the counter.
  - A late ack is ignored while in IDLE with no access.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely; bus_err is tied to 0.

Decomposition:
- Shared package: mem_size_e (BYTE/HALF/WORD), mem_state_e (IDLE/WAIT), MEM/WB struct typedef.
- Sub-module load_align: combinational lane select plus extension (rdata, lane, size, unsigned → 32-bit).

Test Plan:
- Load byte sign: lb at 0x1003, dm_rdata=0x80FF_1234, ack same cycle → wb_data=0xFFFF_FF80, mem_stall never asserted.
- Store half with wait: sh at 0x2002, wdata=0xABCD, ack after 3 cycles → dm_be=4'b1100, dm_wdata=0xABCD_ABCD, mem_stall high for exactly 3 cycles, one bubble per stalled cycle.
- Misaligned: lw at 0x0006 → no dm_req, addr_err pulse, wb_regwrite=0.
- Flush in WAIT: mem_flush asserted during a pending lw, ack arrives 2 cycles later → dm_req held until ack, wb_regwrite=0.
- Mispredict at MEM: branch_at_mem=1, pred=0, ex_avail=1, bpc=0x100 → correct_at_mem=1, correct_pc=0x100. Same inputs with mem_flush=1 → correct_at_mem=0.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=16): no ack → bus_err pulses at WAIT cycle 16, state returns to IDLE, mem_stall deasserts.
